// File: rtl/clock_set_controller.sv
// clock_set_controller: time-set sequencer for the binary hh:mm:ss clock core.
// Walks hours then minutes on debounced mode/inc pulses, freezes the core
// while editing and commits the result through a one-cycle load strobe.
// Optional alarm editing and ringing: define CLOCK_SET_ALARM_EN.
module clock_set_controller #(
   parameter int TIMEOUT_S = 30,
   parameter int HOUR_MOD  = 24
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_1hz,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic [4:0] cur_hours,
   input  logic [5:0] cur_minutes,
   input  logic [5:0] cur_seconds,
   output logic       run_en,
   output logic       load,
   output logic [4:0] load_hours,
   output logic [5:0] load_minutes,
   output logic [4:0] edit_hours,
   output logic [5:0] edit_minutes,
   output logic [1:0] edit_field,
`ifdef CLOCK_SET_ALARM_EN
   output logic       alarm_ring,
`endif
   output logic       blink
);

   typedef enum logic [2:0] {RUN, SET_HH, SET_MM, COMMIT, SET_AH, SET_AM} state_t;

   localparam logic [4:0] HMOD  = 5'(HOUR_MOD);
   localparam logic [4:0] HMAX  = 5'(HOUR_MOD - 1);
   localparam logic [5:0] TO_M1 = 6'(TIMEOUT_S - 1);

   state_t     state;
   logic [5:0] idle_cnt;
   logic       btn_any;

   assign btn_any = btn_mode | btn_inc;

`ifdef CLOCK_SET_ALARM_EN
   logic [4:0] alarm_hours, al_edit_hours;
   logic [5:0] alarm_minutes, al_edit_minutes;
   logic [5:0] ring_cnt;
   logic       alarm_hit;

   // alarm fires on the tick that starts the matching minute while the core runs
   assign alarm_hit = run_en && tick_1hz && (cur_seconds == 6'd0) &&
                      (cur_hours == alarm_hours) && (cur_minutes == alarm_minutes);
`else
   logic unused_sec;
   assign unused_sec = ^cur_seconds;
`endif

   // edit state machine; every output is registered alongside the state
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= RUN;
         run_en       <= 1'b1;
         load         <= 1'b0;
         load_hours   <= '0;
         load_minutes <= '0;
         edit_hours   <= '0;
         edit_minutes <= '0;
         edit_field   <= 2'b00;
         blink        <= 1'b0;
         idle_cnt     <= '0;
`ifdef CLOCK_SET_ALARM_EN
         alarm_hours     <= '0;
         alarm_minutes   <= '0;
         al_edit_hours   <= '0;
         al_edit_minutes <= '0;
         alarm_ring      <= 1'b0;
         ring_cnt        <= '0;
`endif
      end else begin
         load <= 1'b0;
         case (state)
            RUN: begin
               run_en     <= 1'b1;
               blink      <= 1'b0;
               edit_field <= 2'b00;
               idle_cnt   <= '0;
`ifdef CLOCK_SET_ALARM_EN
               // while ringing, any press only silences the alarm
               if (alarm_ring) begin
                  if (btn_any) alarm_ring <= 1'b0;
                  else if (tick_1hz) begin
                     if (ring_cnt == 6'd59) alarm_ring <= 1'b0;
                     else ring_cnt <= ring_cnt + 6'd1;
                  end
               end else if (alarm_hit && !btn_mode) begin
                  alarm_ring <= 1'b1;
                  ring_cnt   <= '0;
               end else
`endif
               if (btn_mode) begin
                  // out-of-range live hours start the edit at 0
                  edit_hours   <= (cur_hours >= HMOD) ? 5'd0 : cur_hours;
                  edit_minutes <= cur_minutes;
                  state        <= SET_HH;
                  run_en       <= 1'b0;
                  edit_field   <= 2'b01;
               end
            end
            COMMIT: begin
               // buttons are ignored here
               state      <= RUN;
               run_en     <= 1'b1;
               edit_field <= 2'b00;
               blink      <= 1'b0;
            end
            default: begin
               if (tick_1hz) blink <= ~blink;
               if (btn_any) idle_cnt <= '0;
               else if (tick_1hz) idle_cnt <= idle_cnt + 6'd1;
               if (btn_mode) begin
                  // mode has priority; inc in the same cycle is dropped
                  blink <= 1'b0;
                  case (state)
                     SET_HH: begin
                        state      <= SET_MM;
                        edit_field <= 2'b10;
                     end
`ifdef CLOCK_SET_ALARM_EN
                     SET_MM: begin
                        state           <= SET_AH;
                        edit_field      <= 2'b11;
                        al_edit_hours   <= alarm_hours;
                        al_edit_minutes <= alarm_minutes;
                     end
                     SET_AH: state <= SET_AM;
`endif
                     default: begin
                        state        <= COMMIT;
                        edit_field   <= 2'b00;
                        load         <= 1'b1;
                        load_hours   <= edit_hours;
                        load_minutes <= edit_minutes;
`ifdef CLOCK_SET_ALARM_EN
                        alarm_hours   <= al_edit_hours;
                        alarm_minutes <= al_edit_minutes;
`endif
                     end
                  endcase
               end else if (btn_inc) begin
                  case (state)
                     SET_HH: edit_hours <= (edit_hours == HMAX) ? 5'd0 : edit_hours + 5'd1;
                     SET_MM: edit_minutes <= (edit_minutes == 6'd59) ? 6'd0 : edit_minutes + 6'd1;
`ifdef CLOCK_SET_ALARM_EN
                     SET_AH: al_edit_hours <= (al_edit_hours == HMAX) ? 5'd0 : al_edit_hours + 5'd1;
                     SET_AM: al_edit_minutes <= (al_edit_minutes == 6'd59) ? 6'd0 : al_edit_minutes + 6'd1;
`endif
                     default: ;
                  endcase
               end else if (tick_1hz && idle_cnt == TO_M1) begin
                  // idle too long: drop the edit, core resumes from frozen value
                  state      <= RUN;
                  run_en     <= 1'b1;
                  edit_field <= 2'b00;
                  blink      <= 1'b0;
                  idle_cnt   <= '0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller (TIMEOUT_S=30, HOUR_MOD=24).
// Covers the alarm path when CLOCK_SET_ALARM_EN is defined.
module tb_clock_set_controller;

   logic       clk = 1'b0;
   logic       reset, tick_1hz, btn_mode, btn_inc;
   logic [4:0] cur_hours;
   logic [5:0] cur_minutes, cur_seconds;
   logic       run_en, load, blink;
   logic [4:0] load_hours, edit_hours;
   logic [5:0] load_minutes, edit_minutes;
   logic [1:0] edit_field;
`ifdef CLOCK_SET_ALARM_EN
   logic       alarm_ring;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   clock_set_controller #(.TIMEOUT_S(30), .HOUR_MOD(24)) dut (
      .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
      .btn_mode(btn_mode), .btn_inc(btn_inc),
      .cur_hours(cur_hours), .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
      .run_en(run_en), .load(load), .load_hours(load_hours), .load_minutes(load_minutes),
      .edit_hours(edit_hours), .edit_minutes(edit_minutes), .edit_field(edit_field),
`ifdef CLOCK_SET_ALARM_EN
      .alarm_ring(alarm_ring),
`endif
      .blink(blink)
   );

   always #5 clk = ~clk;

   // one clock edge, then release the pulse inputs away from the edge
   task automatic step();
      @(posedge clk);
      #1;
      tick_1hz = 1'b0;
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; tick_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
      cur_hours = 5'd0; cur_minutes = 6'd0; cur_seconds = 6'd0;
      #1;
      step(); step();
      reset = 1'b0;

      // reset state
      chk("rst_run_en", run_en, 1); chk("rst_load", load, 0);
      chk("rst_blink", blink, 0);   chk("rst_field", edit_field, 0);
      chk("rst_eh", edit_hours, 0); chk("rst_em", edit_minutes, 0);
      chk("rst_lh", load_hours, 0); chk("rst_lm", load_minutes, 0);

      // ticks in RUN change nothing
      for (int i = 0; i < 5; i++) begin
         tick_1hz = 1'b1; step();
         chk("run_tick_en", run_en, 1); chk("run_tick_load", load, 0);
         chk("run_tick_blink", blink, 0); chk("run_tick_field", edit_field, 0);
      end

      // inc in RUN is ignored
      btn_inc = 1'b1; step();
      chk("run_inc_field", edit_field, 0);

      // full edit 13:45 -> 01:05 with wraps
      cur_hours = 5'd13; cur_minutes = 6'd45;
      btn_mode = 1'b1; step();
      chk("hh_field", edit_field, 1); chk("hh_run_en", run_en, 0);
      chk("hh_cap_h", edit_hours, 13); chk("hh_cap_m", edit_minutes, 45);
      for (int i = 1; i <= 12; i++) begin
         btn_inc = 1'b1; step();
         chk("hh_inc_run_en", run_en, 0);
         if (i == 10) chk("hh_at_23", edit_hours, 23);
         if (i == 11) chk("hh_wrap_0", edit_hours, 0);
      end
      chk("hh_end", edit_hours, 1);
      btn_mode = 1'b1; step();
      chk("mm_field", edit_field, 2); chk("mm_run_en", run_en, 0); chk("mm_blink", blink, 0);
      for (int i = 1; i <= 20; i++) begin
         btn_inc = 1'b1; step();
         chk("mm_inc_run_en", run_en, 0); chk("mm_inc_load", load, 0);
         if (i == 14) chk("mm_at_59", edit_minutes, 59);
         if (i == 15) chk("mm_wrap_0", edit_minutes, 0);
      end
      chk("mm_end", edit_minutes, 5);
      btn_mode = 1'b1; step();
      chk("commit_load", load, 1); chk("commit_lh", load_hours, 1);
      chk("commit_lm", load_minutes, 5); chk("commit_run_en", run_en, 0);
      step();
      chk("post_load", load, 0); chk("post_run_en", run_en, 1);
      chk("post_field", edit_field, 0); chk("post_hold_eh", edit_hours, 1);
      chk("post_hold_em", edit_minutes, 5);

      // timeout after 30 idle ticks, blink toggles on ticks
      cur_hours = 5'd2; cur_minutes = 6'd10;
      btn_mode = 1'b1; step();
      chk("to_enter", edit_field, 1);
      for (int i = 1; i <= 29; i++) begin
         tick_1hz = 1'b1; step();
         chk("to_field", edit_field, 1); chk("to_load", load, 0);
         if (i == 1) chk("blink_on", blink, 1);
         if (i == 2) chk("blink_off", blink, 0);
      end
      tick_1hz = 1'b1; step();
      chk("to_abort_field", edit_field, 0); chk("to_abort_run_en", run_en, 1);
      chk("to_abort_load", load, 0); chk("to_abort_blink", blink, 0);
      step();
      chk("to_after_load", load, 0);

      // same-cycle mode+inc in SET_MM: mode wins; buttons in COMMIT ignored
      btn_mode = 1'b1; step();
      btn_mode = 1'b1; step();
      chk("pri_mm_field", edit_field, 2);
      btn_mode = 1'b1; btn_inc = 1'b1; step();
      chk("pri_load", load, 1); chk("pri_em", edit_minutes, 10);
      chk("pri_lm", load_minutes, 10); chk("pri_lh", load_hours, 2);
      btn_mode = 1'b1; step();
      chk("commit_ign_field", edit_field, 0); chk("commit_ign_run_en", run_en, 1);
      step();
      chk("commit_ign_field2", edit_field, 0);

      // hour sanitising then reset mid-edit
      cur_hours = 5'd25; cur_minutes = 6'd7;
      btn_mode = 1'b1; step();
      chk("san_eh", edit_hours, 0); chk("san_em", edit_minutes, 7);
      for (int i = 0; i < 3; i++) begin btn_inc = 1'b1; step(); end
      chk("rmid_eh", edit_hours, 3);
      reset = 1'b1; step();
      chk("rmid_field", edit_field, 0); chk("rmid_run_en", run_en, 1);
      chk("rmid_load", load, 0); chk("rmid_eh0", edit_hours, 0);
      chk("rmid_em0", edit_minutes, 0);
      reset = 1'b0; step();
      chk("rmid_load2", load, 0);

`ifdef CLOCK_SET_ALARM_EN
      // program alarm to 07:30 and let it ring
      cur_hours = 5'd7; cur_minutes = 6'd30; cur_seconds = 6'd5;
      btn_mode = 1'b1; step();
      btn_mode = 1'b1; step();
      btn_mode = 1'b1; step();
      chk("al_field", edit_field, 3);
      for (int i = 0; i < 7; i++) begin btn_inc = 1'b1; step(); end
      btn_mode = 1'b1; step();
      chk("al_am_field", edit_field, 3);
      for (int i = 0; i < 30; i++) begin btn_inc = 1'b1; step(); end
      btn_mode = 1'b1; step();
      chk("al_commit", load, 1);
      step();
      cur_seconds = 6'd0; tick_1hz = 1'b1; step();
      chk("al_ring", alarm_ring, 1);
      btn_mode = 1'b1; step();
      chk("al_ring_clr", alarm_ring, 0); chk("al_stay_run", edit_field, 0);
      chk("al_run_en", run_en, 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
- Time-set sequencer for the binary hh:mm:ss clock core.
- Takes two debounced user buttons (mode, increment) and runs an edit state machine over hours and then minutes.
- Gates the core's count enable while editing, and commits the edited time to the core's load port with a one-cycle load pulse.
- Sits between the button debouncers and the clock core; the BCD display path reads edit values from it while in set mode.

Parameters:
- TIMEOUT_S, 30, number of tick_1hz pulses without a button press in a SET state before the edit is aborted (1..63).
- HOUR_MOD, 24, hour wrap modulus (12 or 24); edit hours range 0..HOUR_MOD-1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick_1hz  in  1  one-cycle pulse at 1 Hz, synchronous to clk
- btn_mode  in  1  debounced one-cycle press pulse
- btn_inc  in  1  debounced one-cycle press pulse
- cur_hours  in  5  live core hours, binary
- cur_minutes  in  6  live core minutes, binary
- cur_seconds  in  6  live core seconds, binary
- run_en  out  1  core count enable
- load  out  1  one-cycle load strobe to the core; the core loads hours and minutes and clears seconds
- load_hours  out  5  hours value, valid when load=1
- load_minutes  out  6  minutes value, valid when load=1
- edit_hours  out  5  hours currently being edited
- edit_minutes  out  6  minutes currently being edited
- edit_field  out  2  00 none, 01 hours, 10 minutes, 11 alarm field (macro only)
- blink  out  1  display blink for the active field

Behaviour:
- Reset values:
  - state=RUN, run_en=1, load=0, blink=0, edit_field=00.
  - edit_hours=0, edit_minutes=0, idle counter=0.
  - load_hours and load_minutes are registered; both reset to 0.
- RUN:
  - run_en=1, blink=0, edit_field=00.
  - On btn_mode: capture cur_hours and cur_minutes into the edit registers, go to SET_HH.
  - btn_inc is ignored.
- SET_HH:
  - run_en=0, edit_field=01.
  - btn_inc: edit_hours = edit_hours+1, wrapping HOUR_MOD-1 -> 0.
  - btn_mode: go to SET_MM.
- SET_MM:
  - run_en=0, edit_field=10.
  - btn_inc: edit_minutes+1, wrapping 59 -> 0.
  - btn_mode: go to COMMIT.
- COMMIT (exactly one cycle):
  - load=1, load_hours=edit_hours, load_minutes=edit_minutes, run_en=0.
  - Next state RUN; run_en returns to 1 in the following cycle.
- Button priority: btn_mode and btn_inc in the same cycle means btn_mode wins and btn_inc is dropped.
- Buttons arriving during COMMIT are ignored.
- Blink:
  - In SET states, blink toggles on each tick_1hz.
  - blink is forced to 0 on entering any SET state and in RUN/COMMIT.
- Timeout:
  - In SET states the idle counter increments on tick_1hz and clears on any button pulse.
  - If a button and a tick occur in the same cycle, the clear wins.
  - When the counter reaches TIMEOUT_S, go to RUN with no load pulse; the edit is discarded and the core resumes from its frozen value.
- Outputs: edit_hours and edit_minutes hold their last values in RUN.
- Reset mid-edit: returns to RUN immediately, no load issued.
- Hour input sanitising: if the captured cur_hours >= HOUR_MOD, edit_hours is set to 0.
- Latency: button pulse to state/edit register update is 1 clk; run_en is registered.

Optional Feature:
- Macro: CLOCK_SET_ALARM_EN
- With the macro:
  - Adds states SET_AH and SET_AM after SET_MM, both with edit_field=11.
  - The path is SET_MM -> SET_AH -> SET_AM -> COMMIT.
  - Alarm registers alarm_hours (5 bits) and alarm_minutes (6 bits) are updated in COMMIT, alongside the time load.
  - Added output alarm_ring (1 bit, reset 0). It sets when run_en=1, tick_1hz=1, cur_seconds==0, and cur_hours/cur_minutes equal the alarm registers.
  - alarm_ring clears on any button pulse in RUN (that press is consumed, so no SET_HH entry) or after 60 ticks.
- Without the macro: no alarm states, registers or port; edit_field never takes the value 11.

Test Plan:
- Reset then 5 ticks -> run_en=1, load=0, blink=0, edit_field=00 throughout.
- cur=13:45; btn_mode; btn_inc x12; btn_mode; btn_inc x20; btn_mode -> edit_hours passes 23 then 0 and ends at 1; edit_minutes passes 59 then 0 and ends at 5; single-cycle load with load_hours=1, load_minutes=5; run_en=0 from SET_HH entry to COMMIT inclusive.
- Enter SET_HH, then TIMEOUT_S=30 ticks with no buttons -> return to RUN on the 30th tick, no load pulse, run_en=1 next cycle.
- In SET_MM, btn_mode and btn_inc in the same cycle -> COMMIT, edit_minutes unchanged.
- Enter SET_HH, press btn_inc x3, assert reset -> state RUN, load never asserted, edit registers 0.
- CLOCK_SET_ALARM_EN: program alarm to 07:30, then drive cur=07:30:00 with a tick -> alarm_ring=1; next btn_mode -> alarm_ring=0 and state stays RUN.
